// File: rtl/sdpram_rd_pkg.sv
// sdpram_rd_pkg
// Shared definitions for the simple-dual-port RAM burst reader:
//   - rd_state_e   : burst FSM state encoding (IDLE / READ / DRAIN)
//   - DEF_DATA_W   : default RAM word width
//   - DEF_DEPTH    : default RAM word count (power of two)
package sdpram_rd_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 1024;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/sdpram_rd_skid.sv
// sdpram_rd_skid
// Two-entry FIFO holding RAM words that could not be handed to the stream
// consumer in the cycle they returned.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (clears occupancy)
//   push       : write push_data into the tail
//   push_data  : word to store
//   pop        : drop the head entry (caller guarantees count != 0)
//   count      : current occupancy, 0..2
//   head_data  : oldest stored word (meaningful only when count != 0)
module sdpram_rd_skid #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [1:0]        count,
    output logic [DATA_W-1:0] head_data
);

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an empty FIFO never exposes its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/sdpram_burst_reader.sv
// sdpram_burst_reader
// Reads `length` consecutive words from port B of a simple-dual-port RAM
// starting at `start_addr` and presents them in address order on a
// valid/ready stream, one word per cycle when the consumer never stalls.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start, start_addr,
//   length              : burst request (sampled only while idle)
//   busy, done, err     : burst status (done/err are one-cycle pulses)
//   renb, addrb, doutb  : RAM port B (data valid one cycle after renb)
//   m_data, m_valid,
//   m_ready             : output stream
// Build option:
//   SDPRAM_RD_WRAP_EN   : when defined, bursts wrap from DEPTH-1 to 0;
//                         otherwise a burst running past DEPTH-1 is
//                         rejected with an err pulse.
module sdpram_burst_reader
    import sdpram_rd_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              renb,
    output logic [ADDR_W-1:0] addrb,
    input  logic [DATA_W-1:0] doutb,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready
);

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   rd_left_q, rd_left_d;
    logic [ADDR_W:0]   xfer_left_q, xfer_left_d;
    logic              inflight_q, inflight_d;
    logic              done_zero_q, done_zero_d;
    logic              err_q, err_d;

    logic              range_bad;
    logic              accept;
    logic              pop;
    logic              fifo_push;
    logic              fifo_pop;
    logic [1:0]        fifo_count;
    logic [DATA_W-1:0] fifo_head;
    logic [2:0]        occupancy;
    logic              room;

`ifdef SDPRAM_RD_WRAP_EN
    // Address counter is ADDR_W bits wide, so it wraps on its own.
    assign range_bad = 1'b0;
`else
    logic [ADDR_W+1:0] end_addr;
    assign end_addr  = {2'b00, start_addr} + {1'b0, length};
    assign range_bad = end_addr > (ADDR_W+2)'(DEPTH);
`endif

    assign accept = (state_q == ST_IDLE) && start && (length != '0) && !range_bad;

    // A word is visible either from the FIFO head or, when the FIFO is
    // empty, straight from the RAM in the cycle it returns. This bypass is
    // what lets the first word appear two cycles after the start.
    assign m_valid = (fifo_count != 2'd0) || inflight_q;
    assign pop     = m_valid && m_ready;
    assign m_data  = !m_valid            ? '0 :
                     (fifo_count == 2'd0) ? doutb : fifo_head;

    // Returning data is parked unless it is consumed on the bypass path.
    assign fifo_push = inflight_q && !((fifo_count == 2'd0) && pop);
    assign fifo_pop  = pop && (fifo_count != 2'd0);

    // Words already owned (stored + in flight) minus the one leaving now
    // must stay below two for a new read to be safe.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};
    assign room      = occupancy < (3'd2 + {2'b00, pop});

    sdpram_rd_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (doutb),
        .pop       (fifo_pop),
        .count     (fifo_count),
        .head_data (fifo_head)
    );

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept) state_d = ST_READ;
            ST_READ:  if (renb && (rd_left_q == (ADDR_W+1)'(1))) state_d = ST_DRAIN;
            ST_DRAIN: if (pop && (xfer_left_q == (ADDR_W+1)'(1))) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state_q != ST_IDLE);
        renb = (state_q == ST_READ) && (rd_left_q != '0) && room;
        done = done_zero_q || ((state_q == ST_DRAIN) && pop && (xfer_left_q == (ADDR_W+1)'(1)));
    end

    assign addrb = addr_q;
    assign err   = err_q;

    // Burst counters and status pulses
    always_comb begin
        addr_d      = addr_q;
        rd_left_d   = rd_left_q;
        xfer_left_d = xfer_left_q;
        if (accept) begin
            addr_d      = start_addr;
            rd_left_d   = length;
            xfer_left_d = length;
        end else begin
            if (renb) begin
                addr_d    = addr_q + ADDR_W'(1);
                rd_left_d = rd_left_q - (ADDR_W+1)'(1);
            end
            if (pop) begin
                xfer_left_d = xfer_left_q - (ADDR_W+1)'(1);
            end
        end
        inflight_d  = renb;
        done_zero_d = (state_q == ST_IDLE) && start && (length == '0);
        err_d       = (state_q == ST_IDLE) && start && (length != '0) && range_bad;
    end

    // Clearing inflight_q on reset drops any read that returns afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            rd_left_q   <= '0;
            xfer_left_q <= '0;
            inflight_q  <= 1'b0;
            done_zero_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            rd_left_q   <= rd_left_d;
            xfer_left_q <= xfer_left_d;
            inflight_q  <= inflight_d;
            done_zero_q <= done_zero_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_sdpram_burst_reader.sv
`timescale 1ns/1ps
module tb_sdpram_burst_reader;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic [ADDR_W:0]   length = '0;
    logic              busy, done, err, renb, m_valid;
    logic [ADDR_W-1:0] addrb;
    logic [DATA_W-1:0] doutb;
    logic [DATA_W-1:0] m_data;
    logic              m_ready = 1'b1;

    always #5 clk = ~clk;

    sdpram_burst_reader #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .renb       (renb),
        .addrb      (addrb),
        .doutb      (doutb),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready)
    );

    // RAM model: data valid exactly one cycle after renb, junk otherwise.
    logic [DATA_W-1:0] mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h55 + i;
    end
    always @(posedge clk) begin
        doutb <= renb ? mem[addrb] : $urandom;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Consumer: 0 = always ready, 1 = pattern 1,0,0 repeating, 2 = random.
    int ready_mode = 0;
    int ready_ph   = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       begin m_ready = (ready_ph % 3 == 0); ready_ph++; end
            default: m_ready = ($urandom_range(0, 99) < 60);
        endcase
    end

    // Behavioural model: a burst is a list of addresses to read and a list
    // of words to deliver; the DUT may choose when, but not what or in
    // which order.
    logic [DATA_W-1:0] dq[$];
    logic [ADDR_W-1:0] aq[$];
    bit                active, zero_due, err_due, prev_stall;
    logic [DATA_W-1:0] prev_data;
    int                outstanding;
    int                xfer_count = 0;

    function automatic bit range_ok(input int a, input int l);
`ifdef SDPRAM_RD_WRAP_EN
        return 1'b1;
`else
        return (a + l) <= DEPTH;
`endif
    endfunction

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            dq.delete();
            aq.delete();
            active      = 0;
            zero_due    = 0;
            err_due     = 0;
            prev_stall  = 0;
            outstanding = 0;
        end else begin
            bit xfer, last, was_active;
            was_active = active;
            xfer       = m_valid && m_ready;
            last       = 0;
            check("busy", busy, active);
            if (renb) begin
                check("renb_in_burst", aq.size() != 0, 1);
                if (aq.size() != 0) check("addrb", addrb, aq.pop_front());
            end
            if (m_valid) check("valid_in_burst", active, 1);
            if (prev_stall) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, prev_data);
            end
            if (xfer) begin
                xfer_count++;
                check("xfer_expected", dq.size() != 0, 1);
                if (dq.size() != 0) begin
                    check("m_data", m_data, dq.pop_front());
                    last = (dq.size() == 0);
                end
            end
            outstanding += int'(renb) - int'(xfer);
            if (renb) check("outstanding_le2", outstanding <= 2, 1);
            check("done", done, zero_due || (xfer && last && was_active));
            check("err", err, err_due);
            if (xfer && last) active = 0;
            zero_due = 0;
            err_due  = 0;
            if (start && !was_active) begin
                if (length == 0) zero_due = 1;
                else if (!range_ok(int'(start_addr), int'(length))) err_due = 1;
                else begin
                    active = 1;
                    for (int i = 0; i < int'(length); i++) begin
                        logic [ADDR_W-1:0] a;
                        a = ADDR_W'((int'(start_addr) + i) % DEPTH);
                        aq.push_back(a);
                        dq.push_back(mem[a]);
                    end
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    // Per-cycle capture for hand-computed expectations, offset 0 = start cycle.
    logic              cap_valid [16];
    logic              cap_done  [16];
    logic              cap_busy  [16];
    logic              cap_renb  [16];
    logic              cap_err   [16];
    logic [DATA_W-1:0] cap_data  [16];
    logic [ADDR_W-1:0] cap_addr  [16];

    task automatic issue_capture(input logic [ADDR_W-1:0] a, input logic [ADDR_W:0] l, input int n);
        $display("burst addr=0x%03h len=%0d (captured)", a, l);
        @(posedge clk); #1;
        start = 1'b1; start_addr = a; length = l;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap_valid[i] = m_valid; cap_done[i] = done; cap_busy[i] = busy;
            cap_renb[i]  = renb;    cap_err[i]  = err;  cap_data[i] = m_data;
            cap_addr[i]  = addrb;
            if (i == 0) begin
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
    endtask

    task automatic issue(input logic [ADDR_W-1:0] a, input logic [ADDR_W:0] l);
        $display("burst addr=0x%03h len=%0d", a, l);
        @(posedge clk); #1;
        start = 1'b1; start_addr = a; length = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while ((active || busy || zero_due || err_due) && n < budget);
        check("burst_completes", n >= budget, 0);
    endtask

    task automatic check_outputs_zero();
        check("rst_renb", renb, 0);
        check("rst_addrb", addrb, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, n_done;
        #1 rst = 1'b1;
        #1 check_outputs_zero();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Basic burst, consumer always ready.
        ready_mode = 0;
        issue_capture(10'h001, 11'd4, 8);
        check("first_valid_not_early", cap_valid[1], 0);
        check("busy_after_start", cap_busy[1], 1);
        for (int i = 0; i < 4; i++) begin
            check("basic_valid", cap_valid[2+i], 1);
            check("basic_data", cap_data[2+i], 32'h56 + i);
        end
        check("basic_done_cycle", cap_done[5], 1);
        n_done = 0;
        for (int i = 0; i < 8; i++) n_done += int'(cap_done[i]);
        check("basic_done_once", n_done, 1);
        check("basic_busy_drops", cap_busy[6], 0);
        wait_idle(50);

        // Stalling consumer.
        ready_mode = 1;
        base = xfer_count;
        issue(10'h001, 11'd4);
        wait_idle(100);
        check("stall_xfer_count", xfer_count - base, 4);
        issue(10'h080, 11'd12);
        wait_idle(200);

        // Boundary crossing.
        ready_mode = 0;
        issue_capture(10'h3FE, 11'd4, 7);
`ifdef SDPRAM_RD_WRAP_EN
        check("wrap_a0", {cap_renb[1], cap_addr[1]}, {1'b1, 10'h3FE});
        check("wrap_a1", {cap_renb[2], cap_addr[2]}, {1'b1, 10'h3FF});
        check("wrap_a2", {cap_renb[3], cap_addr[3]}, {1'b1, 10'h000});
        check("wrap_a3", {cap_renb[4], cap_addr[4]}, {1'b1, 10'h001});
        check("wrap_d2", cap_data[4], 32'h55 + 32'h000);
`else
        check("bound_err_pulse", cap_err[1], 1);
        check("bound_err_once", cap_err[2], 0);
        check("bound_busy", cap_busy[1], 0);
        for (int i = 0; i < 7; i++) check("bound_no_renb", cap_renb[i], 0);
`endif
        wait_idle(50);

        // Zero-length burst.
        issue_capture(10'h005, 11'd0, 4);
        check("zero_done_early", cap_done[0], 0);
        check("zero_done", cap_done[1], 1);
        check("zero_done_once", cap_done[2], 0);
        for (int i = 0; i < 4; i++) begin
            check("zero_no_renb", cap_renb[i], 0);
            check("zero_no_valid", cap_valid[i], 0);
        end
        wait_idle(20);

        // Reset after 2 of 8 words, then a fresh short burst.
        base = xfer_count;
        issue(10'h040, 11'd8);
        begin
            int n;
            n = 0;
            while (xfer_count - base < 2 && n < 50) begin
                @(negedge clk); #1;
                n++;
            end
            check("mid_reset_reached", n < 50, 1);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1 check_outputs_zero();
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_stale_valid", m_valid, 0);
        end
        base = xfer_count;
        issue_capture(10'h010, 11'd2, 6);
        check("post_rst_d0", cap_data[2], 32'h65);
        check("post_rst_d1", cap_data[3], 32'h66);
        check("post_rst_done", cap_done[3], 1);
        wait_idle(50);
        check("post_rst_xfers", xfer_count - base, 2);

        // Second start while busy is ignored.
        ready_mode = 1;
        base = xfer_count;
        issue(10'h020, 11'd6);
        repeat (3) @(posedge clk);
        #1 start = 1'b1; start_addr = 10'h100; length = 11'd3;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle(200);
        check("ignored_start_xfers", xfer_count - base, 6);

        // Randomized bursts.
        ready_mode = 2;
        for (int k = 0; k < 40; k++) begin
            logic [ADDR_W-1:0] a;
            logic [ADDR_W:0]   l;
            int                r;
            r = $urandom_range(0, 99);
            a = ADDR_W'($urandom_range(0, DEPTH - 1));
            if (r < 10) l = 0;
            else if (r < 20) begin
                a = ADDR_W'($urandom_range(DEPTH - 20, DEPTH - 1));
                l = (ADDR_W+1)'($urandom_range(1, 30));
            end else l = (ADDR_W+1)'($urandom_range(1, 24));
            issue(a, l);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 4)) @(posedge clk);
                #1 start = 1'b1;
                start_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
                length = (ADDR_W+1)'($urandom_range(0, 8));
                @(posedge clk);
                #1 start = 1'b0;
            end
            wait_idle(400);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sdpram_burst_reader.md
SDPRAM_BURST_READER -- requirements
Module: sdpram_burst_reader

Interface
REQ-001 Parameter DATA_W, default 32: RAM word width in bits.
REQ-002 Parameter DEPTH, default 1024: RAM word count, power of two.
REQ-003 Parameter ADDR_W, default $clog2(DEPTH): RAM address width (10 at default).
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle burst request; sampled in IDLE only.
REQ-007 start_addr  input  ADDR_W  first word address of the burst.
REQ-008 length  input  ADDR_W+1  word count, 0..DEPTH.
REQ-009 busy  output  1  high from the cycle after an accepted start until done.
REQ-010 done  output  1  one-cycle pulse when the last word is consumed.
REQ-011 err  output  1  one-cycle pulse on a rejected start.
REQ-012 renb  output  1  RAM port-B read enable.
REQ-013 addrb  output  ADDR_W  RAM port-B read address.
REQ-014 doutb  input  DATA_W  RAM port-B read data, valid exactly 1 cycle after renb.
REQ-015 m_data  output  DATA_W  stream data.
REQ-016 m_valid  output  1  stream valid.
REQ-017 m_ready  input  1  stream ready; a transfer occurs when m_valid and m_ready are both high.

Function
REQ-018 The FSM SHALL have states IDLE, READ and DRAIN.
- IDLE->READ: start with length>0 accepted.
- READ->DRAIN: after the last renb is issued.
- DRAIN->IDLE: after the final transfer, with done asserted that cycle.
REQ-019 A start with length==0 SHALL issue no reads, stay in IDLE and pulse done on the following cycle.
REQ-020 A start outside IDLE SHALL be ignored, with no err and no effect on the current burst.
REQ-021 Read data SHALL land in a 2-entry output FIFO.
- renb is asserted only when (fifo_count + inflight - pop) < 2, where pop = m_valid && m_ready.
- No entry is ever overwritten or lost.
REQ-022 With m_ready held high, the block SHALL sustain one word per cycle.
- First m_valid is 2 cycles after the accepted start.
REQ-023 addrb SHALL equal start_addr for the first read and increment by 1 per issued read.
REQ-024 Words SHALL be presented in address order, and m_data/m_valid SHALL be held stable while m_valid && !m_ready.
REQ-025 renb SHALL be low whenever the state is not READ.
REQ-026 Exactly `length` transfers SHALL occur per burst.

Reset
REQ-027 Asserting rst, including mid-burst, SHALL force the following within the same cycle:
- state IDLE, FIFO and in-flight flag cleared.
- renb=0, addrb=0, m_valid=0, m_data=0.
- busy=0, done=0, err=0.
REQ-028 Read data returning after reset deassertion from a read issued before reset SHALL be discarded.

Configuration
REQ-029 Macro SDPRAM_RD_WRAP_EN:
- Defined: addrb wraps from DEPTH-1 to 0 and any start_addr/length combination is accepted.
- Undefined: a start with start_addr+length > DEPTH pulses err the next cycle, issues no reads and stays in IDLE.

Structure
REQ-030 Package sdpram_rd_pkg SHALL hold the FSM state enum and the default DATA_W/DEPTH constants.
REQ-031 The 2-entry output FIFO SHALL be a sub-module, sdpram_rd_skid, with push/pop/count ports.

Verification
REQ-032 Reset, then start_addr=0x001, length=4, m_ready=1, RAM preloaded mem[n]=0x55+n:
- m_data sequence 0x56, 0x57, 0x58, 0x59 on 4 consecutive cycles.
- done pulses once and busy drops.
REQ-033 Same burst with m_ready toggling 1,0,0,1,...:
- No word is lost or duplicated.
- m_data is stable while stalled.
- renb never leaves more than 2 words outstanding.
REQ-034 Boundary crossing, start_addr=0x3FE, length=4:
- With SDPRAM_RD_WRAP_EN: addresses 0x3FE, 0x3FF, 0x000, 0x001.
- Without: err pulses and renb stays low.
REQ-035 length=0: done pulses 1 cycle after start, with no renb and no m_valid.
REQ-036 rst asserted mid-burst (after 2 of 8 words):
- All outputs are 0 immediately.
- A new burst with start_addr=0x010, length=2 returns mem[0x010], mem[0x011] only.
REQ-037 A second start while busy is ignored; the first burst completes unchanged.
